// File: rtl/io_config_ctrl.sv
// Pad configuration controller: shadow bank loaded over valid/ready,
// applied atomically after a tri-state quiesce window.
module io_config_ctrl #(
  parameter int NUM_IO   = 8,
  parameter int IDX_W    = 3,
  parameter int HOLD_CYC = 2
) (
  input  logic                  IOCLK,
  input  logic                  RST,
  input  logic                  CFG_VALID,
  output logic                  CFG_READY,
  input  logic [IDX_W-1:0]      CFG_IDX,
  input  logic [2:0]            CFG_DATA,
  input  logic                  CFG_LAST,
  output logic [2*NUM_IO-1:0]   TSMUX_OUT,
  output logic [NUM_IO-1:0]     DORREG_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    QUIESCE,
    APPLY
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          shadow [NUM_IO];
  logic [2*NUM_IO-1:0] act_ts;
  logic [NUM_IO-1:0]   act_dor;
  logic                done_q;
  logic                err_q;
  logic                accept;
  logic                in_range;

  assign CFG_READY = (state == IDLE) || (state == LOAD);
  assign BUSY      = (state == QUIESCE) || (state == APPLY);
  assign accept    = CFG_VALID && CFG_READY;
  assign in_range  = int'(CFG_IDX) < NUM_IO;

  // Pads are tri-stated for the whole commit, even ones left unchanged.
  assign TSMUX_OUT  = BUSY ? '0 : act_ts;
  assign DORREG_OUT = act_dor;
  assign DONE       = done_q;
  assign ERR        = err_q;

  always_ff @(posedge IOCLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      act_ts  <= '0;
      act_dor <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_IO; i++)
        shadow[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        for (int i = 0; i < NUM_IO; i++)
          if (in_range && CFG_IDX == IDX_W'(i))
            shadow[i] <= CFG_DATA;
        if (!in_range)
          err_q <= 1'b1;
      end
      unique case (state)
        IDLE, LOAD: begin
          if (accept) begin
            if (CFG_LAST) begin
              state <= QUIESCE;
              cnt   <= CNT_W'(HOLD_CYC - 1);
            end else begin
              state <= LOAD;
            end
          end
        end
        QUIESCE: begin
          if (cnt == '0)
            state <= APPLY;
          else
            cnt <= cnt - 1'b1;
        end
        APPLY: begin
          for (int i = 0; i < NUM_IO; i++) begin
            act_ts[2*i +: 2] <= shadow[i][2:1];
            act_dor[i]       <= shadow[i][0];
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/io_config_ctrl.md
# io_config_ctrl

Configuration controller for a bank of `NUM_IO` I/O pad blocks. It accepts per-pad configuration words over a valid/ready interface into a shadow register bank and drives each pad's output-enable mode (TSMUX) and input-register select (DORREG). A commit runs a quiesce phase: every pad is forced to high-Z for a fixed number of cycles, then the whole shadow bank is applied atomically. This prevents output contention while several pads are reconfigured. It sits between the configuration loader and the I/O ring.

## Interface
Parameters:
- `NUM_IO`, 8, number of I/O blocks controlled.
- `IDX_W`, 3, width of pad index. Must satisfy 2^IDX_W >= NUM_IO.
- `HOLD_CYC`, 2, number of quiesce cycles with all pads tri-stated. Minimum 1.

Ports:
- `IOCLK` in 1: the single clock. All state changes on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `CFG_VALID` in 1: configuration word present.
- `CFG_READY` out 1: controller can accept a word.
- `CFG_IDX` in `IDX_W`: target pad index.
- `CFG_DATA` in 3: [2:1] = TSMUX, [0] = DORREG.
- `CFG_LAST` in 1: commit after this word.
- `TSMUX_OUT` out 2*`NUM_IO`: pad i uses bits [2i+1:2i].
- `DORREG_OUT` out `NUM_IO`: pad i uses bit [i].
- `BUSY` out 1: quiesce in progress.
- `DONE` out 1: one-cycle pulse when the new configuration becomes active.
- `ERR` out 1: sticky out-of-range index flag.

## Operation
- A word is accepted in a cycle where `CFG_VALID` and `CFG_READY` are both 1 at the rising edge.
- An accepted word with `CFG_IDX` < `NUM_IO` writes `CFG_DATA` into shadow[`CFG_IDX`].
  - Repeated writes to the same index: the last write wins.
- An accepted word with `CFG_IDX` >= `NUM_IO`:
  - is discarded and sets `ERR`;
  - still commits if `CFG_LAST`=1.
- `ERR` is cleared only by `RST`.
- The shadow bank is not cleared by a commit. Later commits are incremental.
- FSM states:
  - IDLE: `CFG_READY`=1. An accepted word without LAST goes to LOAD. An accepted word with LAST goes to QUIESCE.
  - LOAD: `CFG_READY`=1. An accepted word with LAST goes to QUIESCE; otherwise stay in LOAD.
  - QUIESCE: `CFG_READY`=0, `BUSY`=1, all `TSMUX_OUT` = 00, `DORREG_OUT` holds its previous active value. The down-counter loads `HOLD_CYC`-1 on entry and decrements each cycle. At 0, go to APPLY.
  - APPLY: on the edge leaving APPLY, active <= shadow. Go to IDLE.
- TSMUX encoding is passed through unchanged to the pads:
  - 00 = always high-Z;
  - 01 = drive when TS=1;
  - 1x = always drive.
- Counter width: clog2(`HOLD_CYC`), minimum 1 bit.
- `CFG_VALID`=1 while `CFG_READY`=0: ignored, with no side effects. The word must be held by the source.

## Timing
- Reset values, visible in the cycle after an edge with `RST`=1:
  - state IDLE;
  - `CFG_READY`=1, `TSMUX_OUT`=0, `DORREG_OUT`=0, `BUSY`=0, `DONE`=0, `ERR`=0;
  - all shadow entries = 000.
- While `RST`=1, no word is accepted.
- All outputs are registered or are decoded from registered state only. There is no combinational path from `CFG_*` inputs to outputs.
- Word with LAST accepted at edge t:
  - cycles t+1 .. t+`HOLD_CYC`: `BUSY`=1, `CFG_READY`=0, `TSMUX_OUT`=0;
  - cycle t+`HOLD_CYC`+1 (APPLY): `BUSY`=1, `CFG_READY`=0, `TSMUX_OUT`=0;
  - cycle t+`HOLD_CYC`+2: `TSMUX_OUT`/`DORREG_OUT` = shadow, `DONE`=1 for exactly this cycle, `BUSY`=0, `CFG_READY`=1.
- A word may be accepted in the `DONE` cycle. It affects only the shadow.
- Commit latency from the LAST acceptance edge to the new config is `HOLD_CYC`+2 cycles.
- Throughput during loading: 1 word per cycle.
- Reset in any state, including mid-QUIESCE or APPLY:
  - takes effect at that edge and applies the reset values;
  - no `DONE` pulse occurs;
  - the pending commit is lost.
- The QUIESCE tri-state is applied even to pads whose configuration does not change.

## Test plan
- Reset then idle, `NUM_IO`=8: all outputs equal the reset values. `CFG_READY`=1 the cycle after `RST` drops.
- Single word: idx=3, data=3'b011, LAST=1, accepted at t (`HOLD_CYC`=2):
  - t+1..t+3: `TSMUX_OUT`=0, `BUSY`=1, `CFG_READY`=0;
  - t+4: `TSMUX_OUT`[7:6]=01, `DORREG_OUT`[3]=1, all other bits 0, `DONE`=1 for one cycle only.
- Burst: idx0=100, idx0=110, idx7=001, with LAST on the last word and `CFG_VALID` held high through the QUIESCE cycles:
  - after DONE, `TSMUX_OUT`[1:0]=11 and `DORREG_OUT`[7]=1;
  - the held word is not accepted until `CFG_READY` returns.
- Incremental commit after the previous test: idx2=010, LAST=1. Pads 0 and 7 keep their values; `TSMUX_OUT`[5:4]=01.
- Out-of-range: idx=7 with `NUM_IO`=6, LAST=1:
  - `ERR`=1 and stays 1 through later commits;
  - the commit still produces `DONE`;
  - the active config is unchanged apart from the quiesce.
- `RST` asserted at the second QUIESCE cycle: next cycle all outputs are at reset values, no `DONE` pulse, `CFG_READY`=1.
